// File: rtl/br_pkg.sv
// Shared funct3 encodings and helpers for RV32I conditional branches.
package br_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_RSV0 = 3'b010;
  localparam logic [2:0] F3_RSV1 = 3'b011;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  function automatic logic f3_is_reserved(input logic [2:0] f3);
    return (f3 == F3_RSV0) || (f3 == F3_RSV1);
  endfunction

endpackage

// File: rtl/br_cond_decode.sv
// Combinational branch-condition decode from funct3 and ALU compare flags.
module br_cond_decode
  import br_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       lt,
  input  logic       ltu,
  output logic       cond,
  output logic       reserved
);

  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = zero;
      F3_BNE:  cond = ~zero;
      F3_BLT:  cond = lt;
      F3_BGE:  cond = ~lt;
      F3_BLTU: cond = ltu;
      F3_BGEU: cond = ~ltu;
      default: cond = 1'b0;
    endcase
  end

  assign reserved = f3_is_reserved(funct3);

endmodule

// File: rtl/jump_control.sv
// Execute-stage branch/jump resolution: PC-source select, its registered copy,
// a saturating taken counter and an illegal-funct3 flag.
module jump_control
  import br_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       funct3,
  input  logic             force_jump,
  input  logic             branch,
  input  logic             zero,
  input  logic             lt,
  input  logic             ltu,
  output logic             branch_mux,
  output logic             branch_mux_q,
  output logic             illegal_br,
  output logic [CNT_W-1:0] taken_cnt
);

  logic cond;
  logic reserved;

  br_cond_decode u_decode (
    .funct3   (funct3),
    .zero     (zero),
    .lt       (lt),
    .ltu      (ltu),
    .cond     (cond),
    .reserved (reserved)
  );

  assign branch_mux = force_jump | (branch & cond);
  assign illegal_br = branch & reserved;

  always_ff @(posedge clk) begin
    if (rst) begin
      branch_mux_q <= 1'b0;
      taken_cnt    <= '0;
    end else begin
      branch_mux_q <= branch_mux;
      // Hold at all-ones instead of wrapping.
      if (branch_mux && (taken_cnt != '1))
        taken_cnt <= taken_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_jump_control.sv
// Scoreboard bench for jump_control: stimulus pushes expectations, a negedge monitor checks.
module tb_jump_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  funct3 = 3'b000;
  logic        force_jump = 1'b0;
  logic        branch = 1'b0;
  logic        zero = 1'b0;
  logic        lt = 1'b0;
  logic        ltu = 1'b0;

  logic        bm, bmq, ill;
  logic [15:0] cnt;
  logic        bm_s, bmq_s, ill_s;
  logic [3:0]  cnt_s;

  always #5 clk = ~clk;

  jump_control #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .funct3(funct3), .force_jump(force_jump),
    .branch(branch), .zero(zero), .lt(lt), .ltu(ltu),
    .branch_mux(bm), .branch_mux_q(bmq), .illegal_br(ill), .taken_cnt(cnt)
  );

  jump_control #(.CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .funct3(funct3), .force_jump(force_jump),
    .branch(branch), .zero(zero), .lt(lt), .ltu(ltu),
    .branch_mux(bm_s), .branch_mux_q(bmq_s), .illegal_br(ill_s), .taken_cnt(cnt_s)
  );

  typedef struct {
    string       name;
    logic        bm;
    logic        ill;
    logic        bmq;
    logic [15:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t sbq[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (owned by the stimulus process only).
  logic        prev_bm  = 1'b0;
  logic        prev_rst = 1'b1;
  logic        mq = 1'b0;
  logic [15:0] mc = '0;
  logic [3:0]  mc4 = '0;

  function automatic logic ref_cond(input logic [2:0] f3, input logic z, input logic l, input logic lu);
    logic c;
    if (f3 == 3'd0) return z;
    if (f3 == 3'd1) return !z;
    if (f3 == 3'd2 || f3 == 3'd3) return 1'b0;
    c = (f3 == 3'd6 || f3 == 3'd7) ? lu : l;
    return (f3 == 3'd5 || f3 == 3'd7) ? !c : c;
  endfunction

  task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s got %0h expected %0h", nm, fld, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sbq.size() > 0) begin
      exp_t e;
      e = sbq.pop_front();
      chk(e.name, "branch_mux",     16'(bm),    16'(e.bm));
      chk(e.name, "illegal_br",     16'(ill),   16'(e.ill));
      chk(e.name, "branch_mux_q",   16'(bmq),   16'(e.bmq));
      chk(e.name, "taken_cnt",      cnt,        e.cnt);
      chk(e.name, "s.branch_mux",   16'(bm_s),  16'(e.bm));
      chk(e.name, "s.illegal_br",   16'(ill_s), 16'(e.ill));
      chk(e.name, "s.branch_mux_q", 16'(bmq_s), 16'(e.bmq));
      chk(e.name, "s.taken_cnt",    16'(cnt_s), 16'(e.cnt4));
    end
  end

  task automatic step(input string nm, input logic r, input logic fj, input logic br,
                      input logic [2:0] f3, input logic z, input logic l, input logic lu);
    exp_t e;
    @(posedge clk);
    if (prev_rst) begin
      mq = 1'b0; mc = '0; mc4 = '0;
    end else begin
      mq = prev_bm;
      if (prev_bm) begin
        if (mc != 16'hFFFF) mc = mc + 16'd1;
        if (mc4 != 4'hF) mc4 = mc4 + 4'd1;
      end
    end
    #1;
    rst = r; force_jump = fj; branch = br; funct3 = f3; zero = z; lt = l; ltu = lu;
    e.name = nm;
    e.bm   = fj | (br & ref_cond(f3, z, l, lu));
    e.ill  = br & (f3 == 3'b010 || f3 == 3'b011);
    e.bmq  = mq;
    e.cnt  = mc;
    e.cnt4 = mc4;
    sbq.push_back(e);
    prev_bm  = e.bm;
    prev_rst = r;
  endtask

  initial begin
    //   name            rst fj br f3      z  lt ltu
    step("rst0",         1, 1, 0, 3'b000, 0, 0, 0);
    step("rst1",         1, 0, 0, 3'b000, 0, 0, 0);
    step("nobranch",     0, 0, 0, 3'b111, 1, 0, 0);
    step("nb_hold",      0, 0, 0, 3'b000, 0, 0, 0);
    step("fjump",        0, 1, 0, 3'b000, 1, 0, 0);
    step("fj_after",     0, 0, 0, 3'b000, 0, 0, 0);
    step("beq_t",        0, 0, 1, 3'b000, 1, 0, 0);
    step("bne_t",        0, 0, 1, 3'b001, 0, 0, 0);
    step("bne_nt",       0, 0, 1, 3'b001, 1, 0, 0);
    step("beq_nt",       0, 0, 1, 3'b000, 0, 0, 0);
    step("blt_t",        0, 0, 1, 3'b100, 0, 1, 0);
    step("blt_nt",       0, 0, 1, 3'b100, 0, 0, 0);
    step("bge_t",        0, 0, 1, 3'b101, 0, 0, 0);
    step("bltu_t",       0, 0, 1, 3'b110, 0, 0, 1);
    step("bgeu_nt",      0, 0, 1, 3'b111, 0, 0, 1);
    step("rsv_010",      0, 0, 1, 3'b010, 1, 1, 1);
    step("rsv_011",      0, 0, 1, 3'b011, 0, 0, 0);
    step("rsv_fj",       0, 1, 1, 3'b010, 0, 0, 0);
    for (int f = 0; f < 8; f++)
      for (int fl = 0; fl < 8; fl++)
        step($sformatf("sweep_f%0d_fl%0d", f, fl), 0, 0, 1, 3'(f),
             fl[2], fl[1], fl[0]);
    for (int f = 0; f < 8; f++)
      step($sformatf("nobr_f%0d", f), 0, 0, 0, 3'(f), 1, 1, 1);
    step("rst_prio",     1, 1, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 21; i++)
      step($sformatf("sat%0d", i), 0, 1, 0, 3'b000, 0, 0, 0);
    step("sat_end",      0, 0, 0, 3'b000, 0, 0, 0);
    step("sat_hold",     0, 0, 0, 3'b000, 0, 0, 0);
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", sbq.size());
    end
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
